hmac_ctrl_if: RTL

//  Parametrised register front-end for keyed-hash cores (HMAC-384/512 family).

---
 rtl/hmac_ctrl_if_pkg.sv | 36 +++
 rtl/hmac_ctrl_if.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_ctrl_if_pkg.sv
// Shared constants and types for the keyed-hash register front-end.
// Holds the register map, CTRL/STATUS bit positions, identity words and the FSM state type.
package hmac_ctrl_if_pkg;

  localparam int unsigned ADDR_NAME0    = 32'h0000_0000;
  localparam int unsigned ADDR_NAME1    = 32'h0000_0004;
  localparam int unsigned ADDR_VERSION0 = 32'h0000_0008;
  localparam int unsigned ADDR_VERSION1 = 32'h0000_000C;
  localparam int unsigned ADDR_CTRL     = 32'h0000_0010;
  localparam int unsigned ADDR_STATUS   = 32'h0000_0018;
  localparam int unsigned KEY_BASE      = 32'h0000_0040;
  localparam int unsigned BLOCK_BASE    = 32'h0000_0080;
  localparam int unsigned TAG_BASE      = 32'h0000_0100;

  localparam int unsigned CTRL_INIT_BIT    = 0;
  localparam int unsigned CTRL_NEXT_BIT    = 1;
  localparam int unsigned CTRL_ZEROIZE_BIT = 2;

  localparam int unsigned STATUS_READY_BIT   = 0;
  localparam int unsigned STATUS_VALID_BIT   = 1;
  localparam int unsigned STATUS_ERR_CMD_BIT = 2;
  localparam int unsigned STATUS_ERR_WR_BIT  = 3;

  // ASCII "hmac", "-if ", "0.10"
  localparam logic [31:0] CORE_NAME0    = 32'h686d_6163;
  localparam logic [31:0] CORE_NAME1    = 32'h2d69_6620;
  localparam logic [31:0] CORE_VERSION0 = 32'h302e_3130;
  localparam logic [31:0] CORE_VERSION1 = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } hmac_ctrl_state_e;

endpackage

// File: rtl/hmac_ctrl_if.sv
// Register front-end for HMAC-384/512 style cores: key/block/tag storage, command
// legality FSM, sticky W1C error flags, zeroize and a done interrupt pulse.
module hmac_ctrl_if
  import hmac_ctrl_if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned KEY_WORDS   = 12,
  parameter int unsigned BLOCK_WORDS = 32,
  parameter int unsigned TAG_WORDS   = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cs,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [31:0]               write_data,
  output logic [31:0]               read_data,
  output logic                      core_init,
  output logic                      core_next,
  output logic                      core_zeroize,
  output logic [KEY_WORDS*32-1:0]   core_key,
  output logic [BLOCK_WORDS*32-1:0] core_block,
  input  logic                      core_ready,
  input  logic [TAG_WORDS*32-1:0]   core_tag,
  input  logic                      core_tag_valid,
  output logic                      irq_done
);

  localparam int unsigned KeyIdxW   = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int unsigned BlockIdxW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int unsigned TagIdxW   = (TAG_WORDS > 1) ? $clog2(TAG_WORDS) : 1;

  localparam logic [ADDR_WIDTH-1:0] AddrName0    = ADDR_WIDTH'(ADDR_NAME0);
  localparam logic [ADDR_WIDTH-1:0] AddrName1    = ADDR_WIDTH'(ADDR_NAME1);
  localparam logic [ADDR_WIDTH-1:0] AddrVersion0 = ADDR_WIDTH'(ADDR_VERSION0);
  localparam logic [ADDR_WIDTH-1:0] AddrVersion1 = ADDR_WIDTH'(ADDR_VERSION1);
  localparam logic [ADDR_WIDTH-1:0] AddrCtrl     = ADDR_WIDTH'(ADDR_CTRL);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus   = ADDR_WIDTH'(ADDR_STATUS);
  localparam logic [ADDR_WIDTH-1:0] KeyLo        = ADDR_WIDTH'(KEY_BASE);
  localparam logic [ADDR_WIDTH-1:0] KeyHi        = ADDR_WIDTH'(KEY_BASE + 4 * KEY_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BlockLo      = ADDR_WIDTH'(BLOCK_BASE);
  localparam logic [ADDR_WIDTH-1:0] BlockHi      = ADDR_WIDTH'(BLOCK_BASE + 4 * BLOCK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] TagLo        = ADDR_WIDTH'(TAG_BASE);
  localparam logic [ADDR_WIDTH-1:0] TagHi        = ADDR_WIDTH'(TAG_BASE + 4 * TAG_WORDS);

  hmac_ctrl_state_e state_q, state_d;

  logic [31:0] key_q   [KEY_WORDS];
  logic [31:0] key_d   [KEY_WORDS];
  logic [31:0] block_q [BLOCK_WORDS];
  logic [31:0] block_d [BLOCK_WORDS];
  logic [31:0] tag_q   [TAG_WORDS];
  logic [31:0] tag_d   [TAG_WORDS];
  logic [31:0] tag_in  [TAG_WORDS];

  logic tag_valid_q, tag_valid_d;
  logic err_cmd_q, err_cmd_d;
  logic err_wr_q, err_wr_d;
  logic tv_prev_q;
  logic init_q, init_d;
  logic next_q, next_d;
  logic zeroize_q, zeroize_d;
  logic irq_q, irq_d;

  logic aligned, key_hit, block_hit, tag_hit;
  logic [KeyIdxW-1:0]   key_idx;
  logic [BlockIdxW-1:0] block_idx;
  logic [TagIdxW-1:0]   tag_idx;
  logic wr, ctrl_wr, status_wr, key_wr, block_wr;
  logic init_req, next_req, zeroize_req, cmd_req, cmd_ok;
  logic tv_rise, ready_now;

  // Address decode; only word-aligned addresses inside a region are mapped.
  assign aligned   = (address[1:0] == 2'b00);
  assign key_hit   = aligned && (address >= KeyLo) && (address < KeyHi);
  assign block_hit = aligned && (address >= BlockLo) && (address < BlockHi);
  assign tag_hit   = aligned && (address >= TagLo) && (address < TagHi);
  assign key_idx   = KeyIdxW'((address - KeyLo) >> 2);
  assign block_idx = BlockIdxW'((address - BlockLo) >> 2);
  assign tag_idx   = TagIdxW'((address - TagLo) >> 2);

  assign wr        = cs & we;
  assign ctrl_wr   = wr && (address == AddrCtrl);
  assign status_wr = wr && (address == AddrStatus);
  assign key_wr    = wr & key_hit;
  assign block_wr  = wr & block_hit;

  assign zeroize_req = ctrl_wr & write_data[CTRL_ZEROIZE_BIT];
  assign init_req    = ctrl_wr & write_data[CTRL_INIT_BIT];
  assign next_req    = ctrl_wr & write_data[CTRL_NEXT_BIT];
  assign cmd_req     = init_req | next_req;
  // init beats next when both are requested, so legality follows init in that case.
  assign cmd_ok      = core_ready & (init_req ? (state_q != BUSY) : (state_q == DONE));

  assign tv_rise   = core_tag_valid & ~tv_prev_q;
  assign ready_now = core_ready & (state_q != BUSY);

  for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key
    assign core_key[(KEY_WORDS-1-i)*32 +: 32] = key_q[i];
  end
  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_block
    assign core_block[(BLOCK_WORDS-1-i)*32 +: 32] = block_q[i];
  end
  for (genvar i = 0; i < TAG_WORDS; i++) begin : g_tag
    assign tag_in[i] = core_tag[(TAG_WORDS-1-i)*32 +: 32];
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    block_d     = block_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    err_cmd_d   = err_cmd_q;
    err_wr_d    = err_wr_q;
    init_d      = 1'b0;
    next_d      = 1'b0;
    zeroize_d   = 1'b0;
    irq_d       = 1'b0;

    // W1C clears first so an error raised in the same cycle still sets the flag.
    if (status_wr) begin
      if (write_data[STATUS_ERR_CMD_BIT]) err_cmd_d = 1'b0;
      if (write_data[STATUS_ERR_WR_BIT])  err_wr_d  = 1'b0;
    end

    if (key_wr) begin
      if (state_q == BUSY) err_wr_d = 1'b1;
      else                 key_d[key_idx] = write_data;
    end
    if (block_wr) begin
      if (state_q == BUSY) err_wr_d = 1'b1;
      else                 block_d[block_idx] = write_data;
    end

    if (zeroize_req) begin
      state_d     = IDLE;
      key_d       = '{default: '0};
      block_d     = '{default: '0};
      tag_d       = '{default: '0};
      tag_valid_d = 1'b0;
      zeroize_d   = 1'b1;
    end else begin
      if (cmd_req) begin
        if (cmd_ok) begin
          state_d     = BUSY;
          tag_d       = '{default: '0};
          tag_valid_d = 1'b0;
          init_d      = init_req;
          next_d      = ~init_req;
        end else begin
          err_cmd_d = 1'b1;
        end
      end
      // A command is never accepted in BUSY, so this cannot collide with one above.
      if ((state_q == BUSY) && tv_rise) begin
        state_d     = DONE;
        tag_d       = tag_in;
        tag_valid_d = 1'b1;
        irq_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      key_q       <= '{default: '0};
      block_q     <= '{default: '0};
      tag_q       <= '{default: '0};
      tag_valid_q <= 1'b0;
      err_cmd_q   <= 1'b0;
      err_wr_q    <= 1'b0;
      tv_prev_q   <= 1'b0;
      init_q      <= 1'b0;
      next_q      <= 1'b0;
      zeroize_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      block_q     <= block_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      err_cmd_q   <= err_cmd_d;
      err_wr_q    <= err_wr_d;
      tv_prev_q   <= core_tag_valid;
      init_q      <= init_d;
      next_q      <= next_d;
      zeroize_q   <= zeroize_d;
      irq_q       <= irq_d;
    end
  end

  assign core_init    = init_q;
  assign core_next    = next_q;
  assign core_zeroize = zeroize_q;
  assign irq_done     = irq_q;

  always_comb begin
    read_data = '0;
    if (key_hit) begin
      read_data = key_q[key_idx];
    end else if (block_hit) begin
      read_data = block_q[block_idx];
    end else if (tag_hit) begin
      read_data = tag_q[tag_idx];
    end else if (address == AddrName0) begin
      read_data = CORE_NAME0;
    end else if (address == AddrName1) begin
      read_data = CORE_NAME1;
    end else if (address == AddrVersion0) begin
      read_data = CORE_VERSION0;
    end else if (address == AddrVersion1) begin
      read_data = CORE_VERSION1;
    end else if (address == AddrStatus) begin
      read_data = {28'h0, err_wr_q, err_cmd_q, tag_valid_q, ready_now};
    end
  end

endmodule
